altr_hps_rst_seq: RTL
=====================

ALTR_HPS_RST_SEQ -- requirements
Module: altr_hps_rst_seq

Interface
REQ-001 Parameter NUM_OUT, default 4, number of sequenced reset outputs (>=1).
REQ-002 Parameter DLY_W, default 8, width of the inter-stage delay counter.
REQ-003 Parameter STEP_DLY, default 16, clk cycles between successive releases (1 <= STEP_DLY <= 2^DLY_W-1).
REQ-004 clk  input  1  sole clock.
REQ-005 i_rst_n  input  1  asynchronous active-low reset, asserted asynchronously and deasserted synchronously to clk (driven by a reset synchronizer).
REQ-006 scan_mode  input  1  1 = scan bypass of all reset outputs.
REQ-007 warm_rst_req  input  1  synchronous level request to re-assert all outputs.
REQ-008 o_rst_n  output  NUM_OUT  sequenced active-low resets; bit 0 released first.
REQ-009 o_seq_done  output  1  high when all outputs released.

Function
REQ-010 States SEQ, DONE, WARM; counter cnt[DLY_W-1:0]; stage index idx; registered release vector rel[NUM_OUT-1:0].
REQ-011 SEQ: cnt increments each cycle; when cnt==STEP_DLY-1, rel[idx] set, cnt cleared, idx incremented.
REQ-012 Bit k of rel deasserts on the (STEP_DLY*(k+1))th rising edge after the first edge with i_rst_n high.
REQ-013 Release of bit NUM_OUT-1: same edge moves SEQ->DONE and sets o_seq_done.
REQ-014 Released bits stay released until warm request or reset; never re-assert individually.
REQ-015 DONE: cnt and idx held; outputs all 1 (non-scan).
REQ-016 warm_rst_req sampled high in SEQ or DONE: next edge -> WARM, rel all 0, o_seq_done 0, cnt 0, idx 0.
REQ-017 WARM: held while warm_rst_req high; sampled low -> next edge SEQ with cnt 0; bit 0 releases STEP_DLY edges after entering SEQ.
REQ-018 warm_rst_req on the same edge as a scheduled release: warm wins; no bit released.
REQ-019 STEP_DLY==1: one bit released per cycle, no idle cycles.
REQ-020 o_rst_n[k] = scan_mode ? i_rst_n : rel[k], purely combinational mux after the flop; o_seq_done is not bypassed.
REQ-021 Unreachable state encodings recover to WARM on next edge.

Reset
REQ-022 i_rst_n low: asynchronously state=SEQ, cnt=0, idx=0, rel=0 (o_rst_n all 0 outside scan), o_seq_done=0.
REQ-023 i_rst_n asserting mid-sequence or in DONE/WARM: immediate clear per REQ-022; sequence restarts from bit 0 after deassertion.
REQ-024 All flops use the same asynchronous reset; no synchronous reset terms besides warm request.

Structure
REQ-025 Shared package altr_hps_rst_seq_pkg holds state enum encoding and default NUM_OUT/DLY_W/STEP_DLY constants.
REQ-026 Scan bypass instantiates altr_hps_mux21 once per output bit (mux_in0=rel[k], mux_in1=i_rst_n, mux_sel=scan_mode); no other sub-module.
REQ-027 Outputs of rel are direct flop outputs feeding the mux; no combinational logic between flop and mux.

Verification (NUM_OUT=4, STEP_DLY=16 unless stated)
REQ-028 Release i_rst_n at edge 0 -> o_rst_n = 0001 at edge 16, 0011 at 32, 0111 at 48, 1111 and o_seq_done=1 at 64.
REQ-029 warm_rst_req high at edge 40 (o_rst_n=0011), low at edge 45 -> o_rst_n=0000 at edge 41, re-enter SEQ at 46, 0001 at 62, done at 110.
REQ-030 In DONE, warm_rst_req pulse 1 cycle -> next edge o_rst_n=0000, done=0; full sequence repeats with 16-cycle spacing.
REQ-031 i_rst_n asserted asynchronously between edges at o_rst_n=0111 -> o_rst_n=0000 without clock edge; restart gives 0001 16 edges after deassertion.
REQ-032 scan_mode=1, toggle i_rst_n -> all o_rst_n follow i_rst_n combinationally; internal sequence and o_seq_done unaffected.
REQ-033 STEP_DLY=1 -> o_rst_n 0001,0011,0111,1111 on edges 1-4; warm request coincident with edge 2 release -> edge 2 shows 0000.

Source files
------------

// File: rtl/altr_hps_rst_seq_pkg.sv
// Shared definitions for the staged reset release sequencer.
package altr_hps_rst_seq_pkg;

  localparam int unsigned DEF_NUM_OUT  = 4;
  localparam int unsigned DEF_DLY_W    = 8;
  localparam int unsigned DEF_STEP_DLY = 16;

  // Encoding 2'b11 is unused and recovers to StWarm.
  typedef enum logic [1:0] {
    StSeq  = 2'b00,
    StDone = 2'b01,
    StWarm = 2'b10
  } seq_state_e;

endpackage

// File: rtl/altr_hps_mux21.sv
// Two-input mux cell used for the scan bypass of each reset output.
module altr_hps_mux21 (
  input  logic mux_in0,
  input  logic mux_in1,
  input  logic mux_sel,
  output logic mux_out
);

  assign mux_out = mux_sel ? mux_in1 : mux_in0;

endmodule

// File: rtl/altr_hps_rst_seq.sv
// Releases NUM_OUT active-low resets one at a time, STEP_DLY cycles apart,
// with a warm-reset request that re-asserts them all and a scan bypass.
module altr_hps_rst_seq
  import altr_hps_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_OUT  = DEF_NUM_OUT,
  parameter int unsigned DLY_W    = DEF_DLY_W,
  parameter int unsigned STEP_DLY = DEF_STEP_DLY
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               scan_mode,
  input  logic               warm_rst_req,
  output logic [NUM_OUT-1:0] o_rst_n,
  output logic               o_seq_done
);

  localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [DLY_W-1:0] CNT_MAX  = DLY_W'(STEP_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  seq_state_e         state;
  logic [DLY_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_OUT-1:0] rel;
  logic               seq_done;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= StSeq;
      cnt      <= '0;
      idx      <= '0;
      rel      <= '0;
      seq_done <= 1'b0;
    end else begin
      case (state)
        StSeq: begin
          // A warm request beats a release scheduled on the same edge.
          if (warm_rst_req) begin
            state    <= StWarm;
            cnt      <= '0;
            idx      <= '0;
            rel      <= '0;
            seq_done <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            rel[idx] <= 1'b1;
            cnt      <= '0;
            if (idx == IDX_LAST) begin
              state    <= StDone;
              seq_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + DLY_W'(1);
          end
        end
        StDone: begin
          if (warm_rst_req) begin
            state    <= StWarm;
            cnt      <= '0;
            idx      <= '0;
            rel      <= '0;
            seq_done <= 1'b0;
          end
        end
        StWarm: begin
          cnt      <= '0;
          idx      <= '0;
          rel      <= '0;
          seq_done <= 1'b0;
          if (!warm_rst_req) begin
            state <= StSeq;
          end
        end
        default: begin
          state    <= StWarm;
          cnt      <= '0;
          idx      <= '0;
          rel      <= '0;
          seq_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_seq_done = seq_done;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_scan_mux
    altr_hps_mux21 u_mux (
      .mux_in0 (rel[k]),
      .mux_in1 (i_rst_n),
      .mux_sel (scan_mode),
      .mux_out (o_rst_n[k])
    );
  end

endmodule
